// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared sizing helpers for the CIC comb chain.
//   clog2_min1 : ceil(log2(n)) with a floor of 1, so that 1-entry
//                structures still get a legal 1-bit index.
//   ch_bits_f  : width of the channel index (CH_BITS).
//   ptr_bits_f : width of a comb stage's circular history pointer.
// No ports (package).
// -----------------------------------------------------------------------------
package cic_pkg;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int ch_bits_f(input int channels);
        return clog2_min1(channels);
    endfunction

    function automatic int ptr_bits_f(input int delay, input int channels);
        return clog2_min1(delay * channels);
    endfunction

    // Widths for the default configuration (1 channel, delay 1).
    localparam int DEFAULT_CH_BITS  = ch_bits_f(1);
    localparam int DEFAULT_PTR_BITS = ptr_bits_f(1, 1);

endpackage

// File: rtl/comb_stage.sv
// -----------------------------------------------------------------------------
// comb_stage
// One comb section: y = x - x[n-DELAY] for the same channel, wrapping
// modulo 2^W. Channels arrive round-robin, so the sample DELAY steps back
// in the same channel is exactly DELAY*CHANNELS valid samples ago; a
// circular history of that depth therefore serves every channel.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_data/i_valid/i_chan : incoming sample, its strobe and channel tag
//   o_data/o_valid/o_chan : registered difference, strobe and channel tag
// o_data/o_chan hold while o_valid is low.
// -----------------------------------------------------------------------------
module comb_stage
    import cic_pkg::*;
#(
    parameter int DELAY    = 1,
    parameter int CHANNELS = 1,
    parameter int W        = 10,
    parameter int CH_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       i_data,
    input  logic               i_valid,
    input  logic [CH_BITS-1:0] i_chan,
    output logic [W-1:0]       o_data,
    output logic               o_valid,
    output logic [CH_BITS-1:0] o_chan
);

    localparam int DEPTH    = DELAY * CHANNELS;
    localparam int PTR_BITS = ptr_bits_f(DELAY, CHANNELS);

    logic [W-1:0]        r_hist [DEPTH];
    logic [PTR_BITS-1:0] r_ptr;
    logic [W-1:0]        r_data;
    logic                r_valid;
    logic [CH_BITS-1:0]  r_chan;

    logic [W-1:0]        w_diff;
    logic [PTR_BITS-1:0] w_ptr_next;

    // Difference against the oldest history entry and next pointer value.
    always_comb begin
        w_diff     = i_data - r_hist[r_ptr];
        w_ptr_next = {PTR_BITS{1'b0}};
        if (r_ptr == PTR_BITS'(DEPTH - 1)) begin
            w_ptr_next = {PTR_BITS{1'b0}};
        end else begin
            w_ptr_next = r_ptr + PTR_BITS'(1);
        end
    end

    // History write, pointer advance and output register; only valid
    // samples touch the history so bubbles leave it intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= {W{1'b0}};
            end
            r_ptr   <= {PTR_BITS{1'b0}};
            r_data  <= {W{1'b0}};
            r_valid <= 1'b0;
            r_chan  <= {CH_BITS{1'b0}};
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_hist[r_ptr] <= i_data;
                r_ptr         <= w_ptr_next;
                r_data        <= w_diff;
                r_chan        <= i_chan;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_chan  = r_chan;

endmodule

// File: rtl/cic_comb_chain.sv
// -----------------------------------------------------------------------------
// cic_comb_chain
// Cascade of STAGES comb sections over CHANNELS time-interleaved channels.
// Each valid input sample is tagged with a round-robin channel index; the
// result appears exactly STAGES cycles later with a one-cycle ready pulse.
// Ports:
//   clk        : clock (rising edge)
//   rst        : synchronous active-high reset, dominates valid
//   stream_in  : two's-complement sample of the current channel
//   valid      : stream_in carries a sample this cycle
//   stream_out : top OUT_BITS of the last stage output (held while ready=0)
//   chan_out   : channel index of stream_out (held while ready=0)
//   ready      : one-cycle strobe for stream_out/chan_out
// Build option: define CIC_COMB_ROUND_EN to round half-up instead of
// truncating when OUT_BITS < IN_BITS (no change in latency).
// -----------------------------------------------------------------------------
module cic_comb_chain
    import cic_pkg::*;
#(
    parameter int  STAGES   = 2,
    parameter int  DELAY    = 1,
    parameter int  CHANNELS = 1,
    parameter int  IN_BITS  = 10,
    parameter int  OUT_BITS = 10,
    localparam int CH_BITS  = ch_bits_f(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_BITS-1:0]  stream_in,
    input  logic                valid,
    output logic [OUT_BITS-1:0] stream_out,
    output logic [CH_BITS-1:0]  chan_out,
    output logic                ready
);

    logic [CH_BITS-1:0] r_chan;

    logic [IN_BITS-1:0] w_data  [STAGES+1];
    logic               w_valid [STAGES+1];
    logic [CH_BITS-1:0] w_chan  [STAGES+1];
    logic [IN_BITS-1:0] w_rounded;

    // Input channel counter: tags each valid sample, then steps round-robin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chan <= {CH_BITS{1'b0}};
        end else if (valid) begin
            if (r_chan == CH_BITS'(CHANNELS - 1)) begin
                r_chan <= {CH_BITS{1'b0}};
            end else begin
                r_chan <= r_chan + CH_BITS'(1);
            end
        end
    end

    assign w_data[0]  = stream_in;
    assign w_valid[0] = valid;
    assign w_chan[0]  = r_chan;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        comb_stage #(
            .DELAY    (DELAY),
            .CHANNELS (CHANNELS),
            .W        (IN_BITS),
            .CH_BITS  (CH_BITS)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_data  (w_data[g]),
            .i_valid (w_valid[g]),
            .i_chan  (w_chan[g]),
            .o_data  (w_data[g+1]),
            .o_valid (w_valid[g+1]),
            .o_chan  (w_chan[g+1])
        );
    end

`ifdef CIC_COMB_ROUND_EN
    // Half an output LSB is added before dropping the low bits.
    if (OUT_BITS < IN_BITS) begin : g_round
        assign w_rounded = w_data[STAGES] + (IN_BITS'(1) << (IN_BITS - OUT_BITS - 1));
    end else begin : g_no_round
        assign w_rounded = w_data[STAGES];
    end
`else
    assign w_rounded = w_data[STAGES];
`endif

    // The last stage register already holds between pulses, so the
    // outputs are taken straight from it to keep latency at STAGES.
    assign stream_out = w_rounded[IN_BITS-1 -: OUT_BITS];
    assign chan_out   = w_chan[STAGES];
    assign ready      = w_valid[STAGES];

endmodule

// File: tb/tb_cic_comb_chain.sv
// -----------------------------------------------------------------------------
// tb_cic_comb_chain
// Four instances of cic_comb_chain in different configurations:
//   d0: STAGES=1 DELAY=1 CHANNELS=1 10/10
//   d1: STAGES=2 DELAY=1 CHANNELS=1 10/10 (defaults)
//   d2: STAGES=1 DELAY=1 CHANNELS=2 10/10
//   d3: STAGES=3 DELAY=2 CHANNELS=3 12/10
// Directed vectors come from a table; random traffic is compared against a
// model that forms each output as the binomial sum
//   y[n] = sum_k (-1)^k C(S,k) x_ch[n-k*M]   (mod 2^IN_BITS)
// over the per-channel sample history, delayed by STAGES cycles.
// -----------------------------------------------------------------------------
module tb_cic_comb_chain;

`ifdef CIC_COMB_ROUND_EN
    localparam int EXP31 = 2;
    localparam bit ROUND = 1'b1;
`else
    localparam int EXP31 = 1;
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v   [4];
    logic [11:0] din [4];

    logic [9:0] so0, so1, so2, so3;
    logic       c0, c1, c2;
    logic [1:0] c3;
    logic       r0, r1, r2, r3;

    always #5 clk = ~clk;

    cic_comb_chain #(.STAGES(1), .DELAY(1), .CHANNELS(1), .IN_BITS(10), .OUT_BITS(10)) d0 (
        .clk(clk), .rst(rst), .stream_in(din[0][9:0]), .valid(v[0]),
        .stream_out(so0), .chan_out(c0), .ready(r0));
    cic_comb_chain #(.STAGES(2), .DELAY(1), .CHANNELS(1), .IN_BITS(10), .OUT_BITS(10)) d1 (
        .clk(clk), .rst(rst), .stream_in(din[1][9:0]), .valid(v[1]),
        .stream_out(so1), .chan_out(c1), .ready(r1));
    cic_comb_chain #(.STAGES(1), .DELAY(1), .CHANNELS(2), .IN_BITS(10), .OUT_BITS(10)) d2 (
        .clk(clk), .rst(rst), .stream_in(din[2][9:0]), .valid(v[2]),
        .stream_out(so2), .chan_out(c2), .ready(r2));
    cic_comb_chain #(.STAGES(3), .DELAY(2), .CHANNELS(3), .IN_BITS(12), .OUT_BITS(10)) d3 (
        .clk(clk), .rst(rst), .stream_in(din[3]), .valid(v[3]),
        .stream_out(so3), .chan_out(c3), .ready(r3));

    int P_S  [4] = '{1, 2, 1, 3};
    int P_M  [4] = '{1, 1, 1, 2};
    int P_C  [4] = '{1, 1, 2, 3};
    int P_IB [4] = '{10, 10, 10, 12};
    int P_OB [4] = '{10, 10, 10, 10};

    // reference model state
    int cnt  [4];
    int nidx [4][3];
    int hist [4][3][1024];
    bit pv   [4][4];
    int pd   [4][4];
    int pc   [4][4];
    int ho_r [4];
    int ho_d [4];
    int ho_c [4];

    // stimulus staging for the next cycle
    bit nv [4];
    int nx [4];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int dut;
        bit r;
        bit vv;
        int x;
        int rdy;
        int out;
        int ch;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) begin
            r = r * (n - i) / (i + 1);
        end
        return r;
    endfunction

    task automatic read_dut(input int d, output int rdy, output int out, output int ch);
        case (d)
            0: begin rdy = int'(r0); out = int'(so0); ch = int'(c0); end
            1: begin rdy = int'(r1); out = int'(so1); ch = int'(c1); end
            2: begin rdy = int'(r2); out = int'(so2); ch = int'(c2); end
            default: begin rdy = int'(r3); out = int'(so3); ch = int'(c3); end
        endcase
    endtask

    task automatic model_edge(input int d, input bit r, input bit vv, input int x);
        longint acc;
        longint mask;
        int     ch;
        int     n;
        int     idx;
        int     s;
        s    = P_S[d];
        mask = (longint'(1) << P_IB[d]) - 1;
        if (r) begin
            cnt[d] = 0;
            for (int c = 0; c < 3; c++) nidx[d][c] = 0;
            for (int k = 0; k < 4; k++) begin
                pv[d][k] = 1'b0; pd[d][k] = 0; pc[d][k] = 0;
            end
            ho_r[d] = 0; ho_d[d] = 0; ho_c[d] = 0;
        end else begin
            for (int k = 3; k > 0; k--) begin
                pv[d][k] = pv[d][k-1]; pd[d][k] = pd[d][k-1]; pc[d][k] = pc[d][k-1];
            end
            pv[d][0] = vv; pd[d][0] = 0; pc[d][0] = 0;
            if (vv) begin
                ch = cnt[d];
                n  = nidx[d][ch];
                hist[d][ch][n] = x;
                acc = 0;
                for (int k = 0; k <= s; k++) begin
                    idx = n - k * P_M[d];
                    if (idx >= 0) begin
                        if (k % 2 == 1) acc = acc - longint'(binom(s, k)) * hist[d][ch][idx];
                        else            acc = acc + longint'(binom(s, k)) * hist[d][ch][idx];
                    end
                end
                acc = acc & mask;
                if (ROUND && P_OB[d] < P_IB[d]) begin
                    acc = (acc + (longint'(1) << (P_IB[d] - P_OB[d] - 1))) & mask;
                end
                pd[d][0] = int'(acc >> (P_IB[d] - P_OB[d]));
                pc[d][0] = ch;
                nidx[d][ch] = n + 1;
                cnt[d] = (ch == P_C[d] - 1) ? 0 : ch + 1;
            end
            ho_r[d] = int'(pv[d][s-1]);
            if (pv[d][s-1]) begin
                ho_d[d] = pd[d][s-1];
                ho_c[d] = pc[d][s-1];
            end
        end
    endtask

    // Apply staged stimulus on the falling edge, clock it, update the
    // model and leave the bench 1 time unit after the rising edge.
    task automatic step(input bit r);
        @(negedge clk);
        rst = r;
        for (int d = 0; d < 4; d++) begin
            v[d]   = nv[d];
            din[d] = 12'(nx[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            model_edge(d, r, nv[d], nx[d] & ((1 << P_IB[d]) - 1));
        end
        #1;
    endtask

    initial begin
        int a_r, a_o, a_c;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            v[d] = 1'b0; din[d] = 12'd0; nv[d] = 1'b0; nx[d] = 0;
        end

        // reset state of every instance
        step(1'b1);
        step(1'b1);
        for (int d = 0; d < 4; d++) begin
            read_dut(d, a_r, a_o, a_c);
            check($sformatf("reset_rdy_d%0d", d), a_r, 0);
            check($sformatf("reset_out_d%0d", d), a_o, 0);
            check($sformatf("reset_chan_d%0d", d), a_c, 0);
        end

        // constant 5, single stage
        vt.push_back('{0, 1'b0, 1'b1, 5, 1, 5, 0});
        vt.push_back('{0, 1'b0, 1'b1, 5, 1, 0, 0});
        vt.push_back('{0, 1'b0, 1'b1, 5, 1, 0, 0});
        vt.push_back('{0, 1'b0, 1'b0, 0, 0, 0, 0});
        // impulse through two stages
        vt.push_back('{1, 1'b0, 1'b1, 1, 0, 0, 0});
        vt.push_back('{1, 1'b0, 1'b1, 0, 1, 1, 0});
        vt.push_back('{1, 1'b0, 1'b1, 0, 1, 'h3FE, 0});
        vt.push_back('{1, 1'b0, 1'b1, 0, 1, 1, 0});
        vt.push_back('{1, 1'b0, 1'b0, 0, 1, 0, 0});
        vt.push_back('{1, 1'b0, 1'b0, 0, 0, 0, 0});
        // two interleaved channels
        vt.push_back('{2, 1'b0, 1'b1, 3, 1, 3, 0});
        vt.push_back('{2, 1'b0, 1'b1, 7, 1, 7, 1});
        vt.push_back('{2, 1'b0, 1'b1, 4, 1, 1, 0});
        vt.push_back('{2, 1'b0, 1'b1, 10, 1, 3, 1});
        vt.push_back('{2, 1'b0, 1'b0, 0, 0, 3, 1});
        // modular wrap
        vt.push_back('{0, 1'b1, 1'b0, 0, 0, 0, 0});
        vt.push_back('{0, 1'b0, 1'b1, 1, 1, 1, 0});
        vt.push_back('{0, 1'b0, 1'b1, 'h3FF, 1, 'h3FE, 0});
        vt.push_back('{0, 1'b0, 1'b1, 0, 1, 1, 0});
        // 12->10 output reduction of value 6
        vt.push_back('{3, 1'b1, 1'b0, 0, 0, 0, 0});
        vt.push_back('{3, 1'b0, 1'b1, 6, 0, 0, 0});
        vt.push_back('{3, 1'b0, 1'b0, 0, 0, 0, 0});
        vt.push_back('{3, 1'b0, 1'b0, 0, 1, EXP31, 0});
        vt.push_back('{3, 1'b0, 1'b0, 0, 0, EXP31, 0});
        // gaps, then reset mid-stream with valid high
        vt.push_back('{1, 1'b1, 1'b0, 0, 0, 0, 0});
        vt.push_back('{1, 1'b0, 1'b1, 3, 0, 0, 0});
        vt.push_back('{1, 1'b0, 1'b0, 0, 1, 3, 0});
        vt.push_back('{1, 1'b0, 1'b0, 0, 0, 3, 0});
        vt.push_back('{1, 1'b0, 1'b1, 4, 0, 3, 0});
        vt.push_back('{1, 1'b0, 1'b1, 9, 1, 'h3FE, 0});
        vt.push_back('{1, 1'b1, 1'b1, 9, 0, 0, 0});
        vt.push_back('{1, 1'b0, 1'b0, 0, 0, 0, 0});
        vt.push_back('{1, 1'b0, 1'b1, 5, 0, 0, 0});
        vt.push_back('{1, 1'b0, 1'b0, 0, 1, 5, 0});

        for (int i = 0; i < vt.size(); i++) begin
            for (int d = 0; d < 4; d++) begin
                nv[d] = 1'b0; nx[d] = 0;
            end
            nv[vt[i].dut] = vt[i].vv;
            nx[vt[i].dut] = vt[i].x;
            step(vt[i].r);
            read_dut(vt[i].dut, a_r, a_o, a_c);
            check($sformatf("vec%0d_rdy", i), a_r, vt[i].rdy);
            check($sformatf("vec%0d_out", i), a_o, vt[i].out);
            check($sformatf("vec%0d_chan", i), a_c, vt[i].ch);
        end

        // random traffic: a fully-valid burst, then gaps and rare resets
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit rr;
            rr = (cyc >= 60) && ($urandom_range(0, 99) == 0);
            for (int d = 0; d < 4; d++) begin
                nv[d] = (cyc < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
                nx[d] = int'($urandom_range(0, 4095));
            end
            step(rr);
            for (int d = 0; d < 4; d++) begin
                read_dut(d, a_r, a_o, a_c);
                check($sformatf("rnd%0d_d%0d_rdy", cyc, d), a_r, ho_r[d]);
                check($sformatf("rnd%0d_d%0d_out", cyc, d), a_o, ho_d[d]);
                check($sformatf("rnd%0d_d%0d_chan", cyc, d), a_c, ho_c[d]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_comb_chain.md
CIC_COMB_CHAIN -- requirements
Module: cic_comb_chain

Interface
REQ-001 SHALL have parameter STAGES, default 2, number of cascaded comb stages (>=1).
REQ-002 SHALL have parameter DELAY, default 1, differential delay M per stage (>=1).
REQ-003 SHALL have parameter CHANNELS, default 1, number of time-interleaved channels (>=1).
REQ-004 SHALL have parameter IN_BITS, default 10, input and internal datapath width.
REQ-005 SHALL have parameter OUT_BITS, default 10, output width (<= IN_BITS).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have port stream_in, input, IN_BITS, two's-complement sample for the current channel.
REQ-009 SHALL have port valid, input, 1, marks stream_in as a sample this cycle.
REQ-010 SHALL have port stream_out, output, OUT_BITS, comb-chain result.
REQ-011 SHALL have port chan_out, output, CH_BITS (= max(1, clog2(CHANNELS))), channel index of stream_out.
REQ-012 SHALL have port ready, output, 1, one-cycle pulse marking stream_out/chan_out valid.

Function
REQ-013 SHALL keep an input channel counter: it assigns the current count to each valid sample, then increments, wrapping CHANNELS-1 -> 0; it holds when valid=0.
REQ-014 Each stage SHALL compute y = x - x[n-DELAY] for the same channel, modulo 2^IN_BITS, with no saturation.
REQ-015 Each stage SHALL hold a DELAY*CHANNELS-deep history with a circular pointer wrapping at DELAY*CHANNELS-1 -> 0, advanced only on that stage's input valid.
REQ-016 Each stage SHALL register its output, valid and channel; total latency from valid to ready SHALL be exactly STAGES cycles.
REQ-017 The pipeline SHALL advance every cycle; bubbles (valid=0) SHALL propagate as ready=0 and SHALL leave histories unchanged.
REQ-018 Back-to-back valid on every cycle SHALL be sustained at one sample per clock.
REQ-019 stream_out SHALL be bits [IN_BITS-1 : IN_BITS-OUT_BITS] of the last stage output (truncation) unless REQ-024 applies.
REQ-020 stream_out and chan_out SHALL hold their last values while ready=0.

Reset
REQ-021 On rst=1 at a clock edge: stream_out=0, chan_out=0, ready=0, all history entries=0, all pointers=0, channel counter=0, all stage valids=0.
REQ-022 rst SHALL take priority over valid; samples in flight at reset are discarded with no ready pulse.

Configuration
REQ-023 Without macro CIC_COMB_ROUND_EN, output SHALL be plain truncation per REQ-019.
REQ-024 With CIC_COMB_ROUND_EN defined and OUT_BITS < IN_BITS, output SHALL be round-half-up: add 2^(IN_BITS-OUT_BITS-1) modulo 2^IN_BITS before truncation; latency unchanged.

Structure
REQ-025 Package cic_pkg SHALL hold the clog2-with-minimum-1 width function and the CH_BITS/pointer-width constants.
REQ-026 One sub-module comb_stage (single stage: history, pointer, subtract, output register) SHALL be instantiated STAGES times by a generate loop.

Verification
REQ-027 STAGES=1, DELAY=1, CHANNELS=1, 10/10 bits: constant 5 on 3 valid cycles -> ready after 1 cycle, outputs 5, 0, 0.
REQ-028 STAGES=2, DELAY=1: impulse 1 then zeros -> outputs 1, -2 (0x3FE), 1, 0 at latency 2.
REQ-029 CHANNELS=2, STAGES=1: inputs A0=3, B0=7, A1=4, B1=10 -> (out, chan) = (3,0), (7,1), (1,0), (3,1).
REQ-030 Wrap: STAGES=1, input 0x001 then 0x3FF (10 bits) -> second output 0x3FE; sample 0x000 after 0x3FF -> 0x001.
REQ-031 IN_BITS=12, OUT_BITS=10, last-stage value 6: without macro -> 1; with CIC_COMB_ROUND_EN -> 2.
REQ-032 valid gaps and rst asserted mid-stream: no ready while gaps or reset; after reset, input 5 -> output 5 (history cleared).
